// File: rtl/edge_gated_scaler.sv
// Captures an operand on start, waits for N qualifying edges on an async event line,
// then returns operand << shift with a one-cycle done pulse and an overflow flag.
module edge_gated_scaler #(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 8,
  parameter int SHIFT_W     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [CNT_W-1:0]   edge_cnt_i,
  input  logic [1:0]         mode_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               event_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   data_o,
  output logic               ovf_o,
  output logic [CNT_W-1:0]   edges_seen_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SCALE = 2'd2
  } state_t;

  // Wide enough that every bit shifted out of WIDTH lands in the upper part.
  localparam int EXT_W = WIDTH + (1 << SHIFT_W);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [WIDTH-1:0]       opnd_q, opnd_d;
  logic [CNT_W-1:0]       target_q, target_d;
  logic [1:0]             mode_q, mode_d;
  logic [SHIFT_W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   ovf_q, ovf_d;

  logic                   rise, fall, edge_hit;
  logic [CNT_W-1:0]       cnt_inc;
  logic [EXT_W-1:0]       ext;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], event_i};
    hist_d  = sync_q[SYNC_STAGES-1];
    rise    = sync_q[SYNC_STAGES-1] & ~hist_q;
    fall    = ~sync_q[SYNC_STAGES-1] & hist_q;
    case (mode_q)
      2'b01:   edge_hit = fall;
      2'b10:   edge_hit = rise | fall;
      default: edge_hit = rise;
    endcase
    cnt_inc = cnt_q + CNT_W'(1);
    ext     = EXT_W'(opnd_q) << shift_q;

    state_d  = state_q;
    opnd_d   = opnd_q;
    target_d = target_q;
    mode_d   = mode_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    data_d   = data_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          opnd_d   = data_i;
          target_d = edge_cnt_i;
          mode_d   = mode_i;
          shift_d  = shift_i;
          cnt_d    = '0;
          state_d  = (edge_cnt_i != '0) ? S_WAIT : S_SCALE;
        end
      end
      S_WAIT: begin
        // Abort beats a coinciding final edge; the counter holds its value.
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (edge_hit) begin
          cnt_d = cnt_inc;
          if (cnt_inc == target_q) state_d = S_SCALE;
        end
      end
      S_SCALE: begin
        state_d = S_IDLE;
        if (!abort_i) begin
          data_d = ext[WIDTH-1:0];
          ovf_d  = |ext[EXT_W-1:WIDTH];
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sync_q   <= '0;
      hist_q   <= 1'b0;
      opnd_q   <= '0;
      target_q <= '0;
      mode_q   <= 2'b00;
      shift_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      opnd_q   <= opnd_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign data_o       = data_q;
  assign ovf_o        = ovf_q;
  assign edges_seen_o = cnt_q;

endmodule

// File: doc/edge_gated_scaler.md
Name: edge_gated_scaler

Overview:
Captures an input word on a start request. It then waits for a programmable number of edges on an asynchronous event line, and returns the word scaled by 2^shift with a one-cycle done pulse. The block is a parametrised, clocked generalisation of the "capture, wait N edges, return doubled value" pattern. It is used as a reusable event-gated result stage in lab testbench and DUT sub-systems.

Parameters:
WIDTH, 32, data path width of data_i/data_o
CNT_W, 8, width of edge count request and edge counter
SHIFT_W, 3, width of shift_i (scale 2^0 .. 2^(2^SHIFT_W-1))
SYNC_STAGES, 2, flop stages synchronising event_i (legal >= 2)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  request; accepted only in IDLE
data_i  input  WIDTH  operand, sampled on accept
edge_cnt_i  input  CNT_W  edges to wait, sampled on accept; 0 = no wait
mode_i  input  2  edge type: 00 rising, 01 falling, 10 any, 11 treated as rising; sampled on accept
shift_i  input  SHIFT_W  left-shift amount, sampled on accept
event_i  input  1  asynchronous event line
abort_i  input  1  cancel current operation
busy_o  output  1  high in any state other than IDLE
done_o  output  1  one-cycle pulse, result valid
data_o  output  WIDTH  scaled result, held until next done
ovf_o  output  1  nonzero bit lost in shift; updated with done_o
edges_seen_o  output  CNT_W  live count of qualifying edges in current op

Behaviour:
- Reset (async assert, sync release): state IDLE. busy_o, done_o, ovf_o = 0. data_o = 0. edges_seen_o = 0. Synchroniser flops = 0.
- Edge detection: event_i passes through SYNC_STAGES flops, then one history flop. An edge is a difference between the last sync stage and the history flop, qualified by the latched mode. Edge-to-detect latency is SYNC_STAGES+1 cycles. Edges are ignored outside WAIT.
- FSM states: IDLE, WAIT, SCALE.
- IDLE: if start_i=1, latch data/edge_cnt/mode/shift and clear the edge counter. Go to WAIT if edge_cnt_i != 0, else go to SCALE. busy_o rises the cycle after accept.
- WAIT: the counter increments on each qualifying edge. When the counter reaches the target (the increment that makes count == target), go to SCALE next cycle. At most one edge is counted per cycle.
- SCALE: in one cycle, register data_o = (data_latched << shift) truncated to WIDTH. Register ovf_o = 1 iff any of the top shift bits of data_latched are 1. done_o = 1 for exactly one cycle. Return to IDLE.
- Latency with edge_cnt=0: accept on edge T, done_o high during cycle T+2 (i.e. after edge T+1 to edge T+2).
- start_i while busy: ignored, with no effect on latched values.
- abort_i in WAIT or SCALE: return to IDLE next cycle, no done_o, data_o/ovf_o unchanged, edges_seen_o holds its value. abort_i and the final edge in the same cycle: abort wins. abort_i in IDLE: no effect. abort_i and start_i together in IDLE: start is accepted.
- Back-to-back: start_i may be accepted in the IDLE cycle following done_o.
- Counter width: edge_cnt_i max value 2^CNT_W-1; the counter never wraps, because the target is reached first.
- shift_i = 0: data_o = data_i, ovf_o = 0.
- Reset asserted mid-operation: immediate return to the reset values above. Any pending operation is lost.

Test Plan:
1. WIDTH=32, data_i=5, shift_i=1, edge_cnt_i=0, pulse start_i -> done_o high exactly 2 cycles after accept, data_o=10, ovf_o=0, busy_o high 1 cycle.
2. data_i=5, shift_i=0, edge_cnt_i=2, mode rising. Toggle event_i every 5 clocks from 0, three toggles -> done_o after 2nd rising edge + SYNC_STAGES+2 cycles. data_o=5, edges_seen_o=2. The falling edge is not counted.
3. Same stimulus with mode any, edge_cnt_i=3 -> done_o after the 3rd toggle is detected, edges_seen_o=3. With mode falling and edge_cnt_i=2, no done_o (only 1 falling edge).
4. WIDTH=8, data_i=8'hC0, shift_i=1 -> data_o=8'h80, ovf_o=1. data_i=8'h01, shift_i=7 -> data_o=8'h80, ovf_o=0.
5. edge_cnt_i=4, abort_i after 2 edges -> IDLE next cycle, no done_o, data_o unchanged from the previous op. A second start_i during WAIT is ignored. Abort in the same cycle as the 4th edge -> no done_o.
6. Assert rst_n=0 mid-WAIT, asynchronously between clock edges -> busy_o, done_o, data_o, ovf_o, edges_seen_o are 0 immediately. After release, a fresh start with data_i=3, shift_i=2 gives data_o=12.
